// File: rtl/if_btb_stage_pkg.sv
`default_nettype none
//==============================================================================
// Module : if_btb_stage_pkg
// Desc   : shared BTB counter encodings, reset PC and counter update helper
// Rev    : 1.0
//==============================================================================
package if_btb_stage_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

  localparam ctr_t        C_CTR_ALLOC = CTR_WT;
  localparam logic [31:0] C_RESET_PC  = 32'h0000_0000;

  function automatic ctr_t ctr_update(input ctr_t i_ctr, input logic i_taken);
    ctr_t w_ctr;
    w_ctr = i_ctr;
    if (i_taken) begin
      if (i_ctr != CTR_ST) w_ctr = ctr_t'(i_ctr + 2'd1);
    end else begin
      if (i_ctr != CTR_SNT) w_ctr = ctr_t'(i_ctr - 2'd1);
    end
    return w_ctr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_btb_stage_if.sv
`default_nettype none
//==============================================================================
// Module : if_btb_stage_if
// Desc   : fetch-stage control, BTB training and fetch-address bundle
// Rev    : 1.0
//==============================================================================
interface if_btb_stage_if;

  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic [31:0] pred_pc;
  logic        hit;

  modport master (
    output stall, redirect, redirect_pc,
    output upd_valid, upd_pc, upd_target, upd_taken,
    input  pc, next_pc, pred_pc, hit
  );

  modport slave (
    input  stall, redirect, redirect_pc,
    input  upd_valid, upd_pc, upd_target, upd_taken,
    output pc, next_pc, pred_pc, hit
  );

endinterface
`default_nettype wire

// File: rtl/if_btb_stage_btb_array.sv
`default_nettype none
//==============================================================================
// Module : if_btb_stage_btb_array
// Desc   : direct-mapped BTB storage, combinational lookup and posedge training
// Rev    : 1.0
//==============================================================================
module if_btb_stage_btb_array
  import if_btb_stage_pkg::*;
#(
  parameter int BTB_ENTRIES = 16
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic [31:0] i_lk_pc,
  output logic             o_lk_hit,
  output logic [31:0]      o_lk_target,
  input  wire logic        i_upd_valid,
  input  wire logic [31:0] i_upd_pc,
  input  wire logic [31:0] i_upd_target,
  input  wire logic        i_upd_taken
);

  localparam int IW = $clog2(BTB_ENTRIES);
  localparam int TW = 30 - IW;

  logic [BTB_ENTRIES-1:0] r_valid;
  logic [TW-1:0]          r_tag    [BTB_ENTRIES];
  logic [31:0]            r_target [BTB_ENTRIES];
  ctr_t                   r_ctr    [BTB_ENTRIES];

  logic [IW-1:0] w_lidx;
  logic [TW-1:0] w_ltag;
  logic [IW-1:0] w_uidx;
  logic [TW-1:0] w_utag;
  logic          w_umatch;
  logic          w_alloc;
  logic          w_train;
  logic          w_unused;

  assign w_lidx   = i_lk_pc[IW+1:2];
  assign w_ltag   = i_lk_pc[31:IW+2];
  assign w_uidx   = i_upd_pc[IW+1:2];
  assign w_utag   = i_upd_pc[31:IW+2];
  assign w_unused = ^{i_lk_pc[1:0], i_upd_pc[1:0]};

  // Lookup reads pre-update state; writes become visible next cycle.
  assign o_lk_hit    = r_valid[w_lidx] && (r_tag[w_lidx] == w_ltag) && r_ctr[w_lidx][1];
  assign o_lk_target = r_target[w_lidx];

  assign w_umatch = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
  assign w_alloc  = i_upd_valid && !w_umatch && i_upd_taken;
  assign w_train  = i_upd_valid && w_umatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (w_alloc) begin
      r_valid[w_uidx] <= 1'b1;
    end
  end

  // Payload is unreset: it is only observed through a set valid bit, and
  // allocation rewrites every field.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_tag[w_uidx]    <= w_utag;
      r_target[w_uidx] <= i_upd_target;
      r_ctr[w_uidx]    <= C_CTR_ALLOC;
    end else if (w_train) begin
      r_ctr[w_uidx] <= ctr_update(r_ctr[w_uidx], i_upd_taken);
      if (i_upd_taken) r_target[w_uidx] <= i_upd_target;
    end
  end

endmodule
`default_nettype wire

// File: rtl/if_btb_stage.sv
`default_nettype none
//==============================================================================
// Module : if_btb_stage
// Desc   : fetch PC register with redirect/stall/BTB-predicted next-PC select
// Rev    : 1.0
//==============================================================================
module if_btb_stage
  import if_btb_stage_pkg::*;
#(
  parameter int          BTB_ENTRIES = 16,
  parameter logic [31:0] RESET_PC    = C_RESET_PC
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  if_btb_stage_if.slave io_fetch
);

  logic [31:0] r_pc;
  logic [31:0] w_next_pc;
  logic [31:0] w_pred_pc;
  logic [31:0] w_pc_d;
  logic [31:0] w_btb_target;
  logic        w_btb_hit;
  logic        w_unused;

  if_btb_stage_btb_array #(
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb_array (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_lk_pc      (r_pc),
    .o_lk_hit     (w_btb_hit),
    .o_lk_target  (w_btb_target),
    .i_upd_valid  (io_fetch.upd_valid),
    .i_upd_pc     (io_fetch.upd_pc),
    .i_upd_target (io_fetch.upd_target),
    .i_upd_taken  (io_fetch.upd_taken)
  );

  assign w_next_pc = r_pc + 32'd4;
  assign w_pred_pc = w_btb_hit ? w_btb_target : w_next_pc;
  assign w_unused  = ^io_fetch.redirect_pc[1:0];

  always_comb begin
    w_pc_d = {w_pred_pc[31:2], 2'b00};
    if (io_fetch.redirect) begin
      w_pc_d = {io_fetch.redirect_pc[31:2], 2'b00};
    end else if (io_fetch.stall) begin
      w_pc_d = r_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_d;
    end
  end

  assign io_fetch.pc      = r_pc;
  assign io_fetch.next_pc = w_next_pc;
  assign io_fetch.pred_pc = w_pred_pc;
  assign io_fetch.hit     = w_btb_hit;

endmodule
`default_nettype wire

// File: tb/tb_if_btb_stage.sv
`default_nettype none
//==============================================================================
// Module : tb_if_btb_stage
// Desc   : vector-table and scoreboard bench for the fetch/BTB stage
// Rev    : 1.0
//==============================================================================
module tb_if_btb_stage;

  localparam logic [31:0] C_RESET_PC = 32'h0000_0100;

  typedef struct {
    logic        st;
    logic        rd;
    logic [31:0] rpc;
    logic        uv;
    logic [31:0] upc;
    logic [31:0] utg;
    logic        utk;
    logic [31:0] epc;
    logic        ehit;
    logic [31:0] epred;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic        hit;
    logic [31:0] pred;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  vec_t vecs[$];
  exp_t sb[$];

  if_btb_stage_if bus ();

  if_btb_stage #(
    .BTB_ENTRIES (16),
    .RESET_PC    (C_RESET_PC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .io_fetch (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] epc,
                       input logic ehit, input logic [31:0] epred);
    logic [31:0] enext;
    enext = epc + 32'd4;
    n_vec++;
    if (bus.pc !== epc || bus.hit !== ehit || bus.pred_pc !== epred || bus.next_pc !== enext) begin
      n_err++;
      $display("FAIL %s: got pc=%h hit=%b pred=%h next=%h, want pc=%h hit=%b pred=%h next=%h",
               name, bus.pc, bus.hit, bus.pred_pc, bus.next_pc, epc, ehit, epred, enext);
    end
  endtask

  task automatic drive(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic uv, input logic [31:0] upc,
                       input logic [31:0] utg, input logic utk);
    bus.stall       = st;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.upd_valid   = uv;
    bus.upd_pc      = upc;
    bus.upd_target  = utg;
    bus.upd_taken   = utk;
  endtask

  task automatic add(input logic st, input logic rd, input logic [31:0] rpc,
                     input logic uv, input logic [31:0] upc, input logic [31:0] utg,
                     input logic utk, input logic [31:0] epc, input logic ehit,
                     input logic [31:0] epred);
    vecs.push_back('{st, rd, rpc, uv, upc, utg, utk, epc, ehit, epred});
  endtask

  // Called at a negedge: drive one cycle, expect the post-edge state.
  task automatic apply(input int id, input vec_t v);
    exp_t e;
    drive(v.st, v.rd, v.rpc, v.uv, v.upc, v.utg, v.utk);
    sb.push_back('{id, v.epc, v.ehit, v.epred});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_empty: got 0 entries, want 1");
    end else begin
      e = sb.pop_front();
      check($sformatf("vec%0d", e.id), e.pc, e.hit, e.pred);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    //   st rd rpc            uv upc          utg          utk  epc            hit pred
    add(0, 0, 32'h0,         0, 32'h0,      32'h0,       0,   32'h104,       0, 32'h108);
    add(0, 0, 32'h0,         0, 32'h0,      32'h0,       0,   32'h108,       0, 32'h10C);
    add(0, 0, 32'h0,         1, 32'h108,    32'h200,     1,   32'h10C,       0, 32'h110);
    add(0, 1, 32'h108,       0, 32'h0,      32'h0,       0,   32'h108,       1, 32'h200);
    add(0, 0, 32'h0,         0, 32'h0,      32'h0,       0,   32'h200,       0, 32'h204);
    add(0, 1, 32'h108,       1, 32'h108,    32'h0,       0,   32'h108,       0, 32'h10C);
    add(1, 0, 32'h0,         1, 32'h108,    32'h200,     1,   32'h108,       1, 32'h200);
    add(1, 0, 32'h0,         1, 32'h108,    32'h200,     1,   32'h108,       1, 32'h200);
    add(1, 0, 32'h0,         1, 32'h108,    32'h200,     1,   32'h108,       1, 32'h200);
    add(1, 0, 32'h0,         1, 32'h108,    32'h0,       0,   32'h108,       1, 32'h200);
    add(1, 0, 32'h0,         1, 32'h108,    32'h0,       0,   32'h108,       0, 32'h10C);
    add(1, 0, 32'h0,         1, 32'h108,    32'h0,       0,   32'h108,       0, 32'h10C);
    add(1, 0, 32'h0,         1, 32'h108,    32'h0,       0,   32'h108,       0, 32'h10C);
    add(1, 0, 32'h0,         1, 32'h108,    32'h200,     1,   32'h108,       0, 32'h10C);
    add(1, 0, 32'h0,         1, 32'h108,    32'h200,     1,   32'h108,       1, 32'h200);
    add(0, 0, 32'h0,         0, 32'h0,      32'h0,       0,   32'h200,       0, 32'h204);
    add(1, 1, 32'h3F3,       0, 32'h0,      32'h0,       0,   32'h3F0,       0, 32'h3F4);
    add(1, 0, 32'h0,         0, 32'h0,      32'h0,       0,   32'h3F0,       0, 32'h3F4);
    add(1, 0, 32'h0,         0, 32'h0,      32'h0,       0,   32'h3F0,       0, 32'h3F4);
    add(1, 0, 32'h0,         0, 32'h0,      32'h0,       0,   32'h3F0,       0, 32'h3F4);
    add(0, 1, 32'h108,       0, 32'h0,      32'h0,       0,   32'h108,       1, 32'h200);
    add(1, 0, 32'h0,         1, 32'h148,    32'h300,     1,   32'h108,       0, 32'h10C);
    add(0, 1, 32'h148,       0, 32'h0,      32'h0,       0,   32'h148,       1, 32'h300);
    add(0, 0, 32'h0,         1, 32'h148,    32'h400,     1,   32'h300,       0, 32'h304);
    add(0, 1, 32'h148,       0, 32'h0,      32'h0,       0,   32'h148,       1, 32'h400);
    add(0, 1, 32'hFFFF_FFFC, 0, 32'h0,      32'h0,       0,   32'hFFFF_FFFC, 0, 32'h0);
    add(0, 0, 32'h0,         0, 32'h0,      32'h0,       0,   32'h0,         0, 32'h4);
    add(0, 1, 32'h14A,       1, 32'h188,    32'h600,     0,   32'h148,       1, 32'h400);
    add(0, 1, 32'h188,       0, 32'h0,      32'h0,       0,   32'h188,       0, 32'h18C);

    drive(0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("reset_hold", C_RESET_PC, 1'b0, C_RESET_PC + 32'd4);
    end
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(i, vecs[i]);
    end

    // Asynchronous reset mid-cycle while a taken update to 0x1C0 is pending.
    drive(0, 0, 32'h0, 1, 32'h1C0, 32'h500, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_now", C_RESET_PC, 1'b0, C_RESET_PC + 32'd4);
    @(posedge clk);
    #1;
    check("async_reset_edge", C_RESET_PC, 1'b0, C_RESET_PC + 32'd4);
    @(negedge clk);
    rst_n = 1'b1;
    apply(100, '{0, 1, 32'h148, 0, 32'h0, 32'h0, 0, 32'h148, 0, 32'h14C});
    apply(101, '{0, 1, 32'h1C0, 0, 32'h0, 32'h0, 0, 32'h1C0, 0, 32'h1C4});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_btb_stage.md
# if_btb_stage

Instruction-fetch stage: holds the program counter, drives the instruction-memory address, and predicts the next PC with a direct-mapped branch target buffer (BTB) using 2-bit saturating counters. It sits directly upstream of the IF/ID pipeline register.
- Its `next_pc` and `hit` outputs feed that register's `next_pc` and `hit` inputs.
- The instruction word comes from instruction memory addressed by `pc`.
- Branch resolution from EX drives redirect and BTB training.

## Interface
- `BTB_ENTRIES`, 16: number of BTB entries; power of two, ≥ 2.
- `RESET_PC`, 32'h0000_0000: PC value after reset; bits [1:0] must be 0.
- `clk`  in  1: single clock; all state updates on posedge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `stall`  in  1: hold PC (hazard from decode).
- `redirect`  in  1: misprediction detected in EX; load `redirect_pc`.
- `redirect_pc`  in  32: corrected fetch address.
- `upd_valid`  in  1: a resolved branch is presented for BTB training.
- `upd_pc`  in  32: address of the resolved branch.
- `upd_target`  in  32: resolved branch target.
- `upd_taken`  in  1: resolved direction.
- `pc`  out  32: current fetch address (instruction-memory address).
- `next_pc`  out  32: `pc + 4`, modulo 2^32.
- `pred_pc`  out  32: predicted next fetch address.
- `hit`  out  1: BTB tag match with predict-taken counter.

## Operation
- Index is `pc[IW+1:2]`, where IW = log2(BTB_ENTRIES). Tag is `pc[31:IW+2]`.
- Each entry holds:
  - `valid` (1 bit)
  - tag
  - target (32 bits)
  - 2-bit counter: 00 SNT, 01 WNT, 10 WT, 11 ST
- Lookup is combinational on the registered `pc`.
  - `hit` = valid & tag match & counter[1].
  - `pred_pc` = `hit` ? stored target : `next_pc`.
- PC next-state priority is: `redirect` (load `redirect_pc & ~3`) > `stall` (hold) > `pred_pc`. `redirect` overrides `stall`.
- Training, when `upd_valid` is high, indexed and tagged by `upd_pc`:
  - Tag match, taken: counter saturating +1 (11 stays 11); target ← `upd_target`.
  - Tag match, not taken: counter saturating −1 (00 stays 00); target unchanged.
  - Miss, taken: allocate and overwrite the entry. Set valid=1, tag, target, counter=10.
  - Miss, not taken: no change.
- Training is independent of `stall` and `redirect`; both may occur in the same cycle.
- Reset values:
  - `pc` = `RESET_PC`.
  - All `valid` bits = 0, so `hit` = 0 and `pred_pc` = `RESET_PC + 4`.
  - Counters and targets need no reset.

## Timing
- PC register and BTB writes commit on posedge `clk`. Outputs are valid combinationally from the registered state within the same cycle.
- Redirect penalty: `redirect` asserted in cycle N produces `pc` = `redirect_pc` in cycle N+1.
- Same-cycle update and lookup to one index: the lookup sees the pre-update contents. The update is visible from the next cycle.
- `stall` held for K cycles keeps `pc` constant for K cycles. Training continues during the stall and may change `hit`/`pred_pc` for the held `pc`.
- Asynchronous reset asserted mid-operation immediately forces the reset values; any in-flight update in that cycle is dropped.
- Deassertion is sampled at the next posedge. The first `pc` change occurs on the first posedge with `rst_n`=1.
- `pc + 4` at 32'hFFFF_FFFC wraps to 0.
- Low bits: `redirect_pc[1:0]` are ignored; `pc[1:0]` is always 00.

## Structure
- Shared package holds:
  - counter encodings SNT/WNT/WT/ST
  - the counter-on-allocate value (WT)
  - the default `RESET_PC`
  - the saturating-counter update function
- Sub-module `btb_array` holds storage, the valid vector, the combinational lookup port and the posedge update port. It is parameterised by `BTB_ENTRIES`.
- The top level holds the PC register, the next-PC priority mux and the `pc + 4` adder.

## Test plan
- Reset: hold `rst_n`=0 with `RESET_PC`=0x100 → `pc`=0x100, `hit`=0, `pred_pc`=0x104. Release → `pc` steps 0x104, 0x108, …
- Allocate and predict: update `upd_pc`=0x108, `upd_target`=0x200, taken. Redirect to 0x108 → `hit`=1, `pred_pc`=0x200, next cycle `pc`=0x200.
- Counter hysteresis on the 0x108 entry:
  - One not-taken update → WNT, `hit`=0.
  - Two taken updates → ST.
  - One not-taken → WT, `hit` stays 1.
  - 00 and 11 saturate.
- Priority: `stall`=1 and `redirect`=1 with `redirect_pc`=0x3F3 → `pc`=0x3F0. `stall` alone for 3 cycles → `pc` unchanged.
- Aliasing and same-cycle: with 16 entries, taken update at 0x148 evicts the 0x108 entry. An update and a lookup of index 2 in one cycle → old result that cycle, new result the next.
- Reset mid-run: assert `rst_n`=0 while `upd_valid`=1 → update lost, all `hit`=0, `pc`=`RESET_PC` immediately without a clock edge.
